// File: rtl/qpd_demod_sequencer.sv
// Time-shares one signed NUM_BITS x NUM_BITS multiplier across the four QPD demodulation lanes.
// Optional build macro: QPD_SEQ_OVERRUN_CNT_EN adds a saturating dropped-tick counter port.
module qpd_demod_sequencer #(
  parameter int NUM_BITS = 24
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                tick_i,
  input  logic [NUM_BITS-1:0] diff_i,
  input  logic [NUM_BITS-1:0] sum_i,
  input  logic [NUM_BITS-1:0] sin_i,
  input  logic [NUM_BITS-1:0] cos_i,
  output logic [NUM_BITS-1:0] product_o,
  output logic [1:0]          lane_o,
  output logic                product_valid_o,
  input  logic                product_ready_i,
  input  logic                filt_done_i,
  output logic                done_o,
  output logic                busy_o,
  output logic                overrun_o,
`ifdef QPD_SEQ_OVERRUN_CNT_EN
  output logic [7:0]          overrun_cnt_o,
`endif
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_DONE} state_t;

  // Stream handshake: a product transfers on any edge where product_valid_o && product_ready_i;
  // once valid is raised, product_o and lane_o hold until that transfer happens.

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [NUM_BITS-1:0] diff_q, sum_q, sin_q, cos_q;
  logic [NUM_BITS-1:0] prod_q, prod_d;
  logic [1:0]          lane_q, lane_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                ovr_q, ovr_d;
  logic                capture;
  logic                adv;

  logic signed [NUM_BITS-1:0]   op_a, op_b;
  logic signed [2*NUM_BITS-1:0] full_prod;

  // Lane bit 1 selects diff/sum, bit 0 selects sin/cos.
  assign op_a      = cnt_q[1] ? sum_q : diff_q;
  assign op_b      = cnt_q[0] ? cos_q : sin_q;
  assign full_prod = op_a * op_b;
  assign adv       = !valid_q || product_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    lane_d  = lane_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_i) begin
          capture = 1'b1;
          cnt_d   = 2'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (adv) begin
          prod_d  = full_prod[2*NUM_BITS-1:NUM_BITS];
          lane_d  = cnt_q;
          valid_d = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = DRAIN;
        end
        if (tick_i) ovr_d = 1'b1;
      end
      DRAIN: begin
        if (valid_q && product_ready_i) begin
          valid_d = 1'b0;
          state_d = WAIT_DONE;
        end
        if (tick_i) ovr_d = 1'b1;
      end
      WAIT_DONE: begin
        if (filt_done_i) begin
          done_d = 1'b1;
          if (tick_i) begin
            capture = 1'b1;
            cnt_d   = 2'd0;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else if (tick_i) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      diff_q  <= '0;
      sum_q   <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
      prod_q  <= '0;
      lane_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      if (capture) begin
        diff_q <= diff_i;
        sum_q  <= sum_i;
        sin_q  <= sin_i;
        cos_q  <= cos_i;
      end
    end
  end

`ifdef QPD_SEQ_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (ovr_d && ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) ovr_cnt_q <= '0;
    else           ovr_cnt_q <= ovr_cnt_d;
  end

  assign overrun_cnt_o = ovr_cnt_q;
`endif

  assign product_o       = prod_q;
  assign lane_o          = lane_q;
  assign product_valid_o = valid_q;
  assign done_o          = done_q;
  assign overrun_o       = ovr_q;
  assign busy_o          = (state_q != IDLE);
  assign state_o         = state_q;

endmodule

// File: tb/tb_qpd_demod_sequencer.sv
// Scoreboard bench for qpd_demod_sequencer: directed frames from the test plan plus randomized frames.
module tb_qpd_demod_sequencer;
  localparam int N = 24;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         tick = 1'b0;
  logic [N-1:0] diff = '0, sum = '0, sn = '0, cs = '0;
  logic [N-1:0] product;
  logic [1:0]   lane;
  logic         product_valid;
  logic         product_ready = 1'b1;
  logic         filt_done = 1'b0;
  logic         done, busy, overrun;
  logic [1:0]   state_dbg;
`ifdef QPD_SEQ_OVERRUN_CNT_EN
  logic [7:0]   overrun_cnt;
`endif

  qpd_demod_sequencer #(.NUM_BITS(N)) dut (
    .clk_i(clk), .reset_ni(reset_n), .tick_i(tick),
    .diff_i(diff), .sum_i(sum), .sin_i(sn), .cos_i(cs),
    .product_o(product), .lane_o(lane), .product_valid_o(product_valid),
    .product_ready_i(product_ready), .filt_done_i(filt_done),
    .done_o(done), .busy_o(busy), .overrun_o(overrun),
`ifdef QPD_SEQ_OVERRUN_CNT_EN
    .overrun_cnt_o(overrun_cnt),
`endif
    .state_o(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [N+1:0] exp_q[$];
  int done_seen = 0, ovr_seen = 0;
  int exp_done = 0, exp_ovr = 0, exp_ovr_since_rst = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: upper half of the full signed product.
  function automatic logic [N-1:0] hi_prod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint pa, pb, p;
    pa = longint'(signed'(a));
    pb = longint'(signed'(b));
    p  = pa * pb;
    return N'(p >>> N);
  endfunction

  task automatic push_frame(input logic [N-1:0] d, input logic [N-1:0] s,
                            input logic [N-1:0] si, input logic [N-1:0] co);
    exp_q.push_back({2'd0, hi_prod(d, si)});
    exp_q.push_back({2'd1, hi_prod(d, co)});
    exp_q.push_back({2'd2, hi_prod(s, si)});
    exp_q.push_back({2'd3, hi_prod(s, co)});
  endtask

  // Monitor: pops on every transfer and checks stall stability.
  logic         stall_pend = 1'b0;
  logic [N+1:0] stall_val;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) check("stall_stable", {lane, product}, stall_val);
      if (product_valid && product_ready) begin
        if (exp_q.size() == 0) check("unexpected_product", {lane, product}, '1);
        else check("product", {lane, product}, exp_q.pop_front());
      end
      stall_pend = product_valid && !product_ready;
      stall_val  = {lane, product};
      if (done) done_seen++;
      if (overrun) ovr_seen++;
    end
  end

  task automatic start_frame(input logic [N-1:0] d, input logic [N-1:0] s,
                             input logic [N-1:0] si, input logic [N-1:0] co);
    diff = d; sum = s; sn = si; cs = co;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    push_frame(d, s, si, co);
  endtask

  task automatic drop_tick();
    tick = 1'b1;
    diff = N'($urandom); sum = N'($urandom);
    @(posedge clk); #1;
    tick = 1'b0;
    exp_ovr++;
    exp_ovr_since_rst++;
  endtask

  task automatic wait_empty();
    int i;
    for (i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 0);
    #1;
  endtask

  task automatic finish_frame(input int delay);
    wait_empty();
    repeat (delay) @(posedge clk);
    #1;
    check("busy_wait_done", busy, 1'b1);
    filt_done = 1'b1;
    @(posedge clk); #1;
    filt_done = 1'b0;
    exp_done++;
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {product, lane, product_valid, done, busy, overrun, state_dbg}, '0);
`ifdef QPD_SEQ_OVERRUN_CNT_EN
    check({name, "_cnt"}, overrun_cnt, 8'd0);
`endif
  endtask

  logic stop_rand;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset_state");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Product values with latency check.
    start_frame(24'h400000, 24'hC00000, 24'h400000, 24'h200000);
    @(negedge clk);
    check("valid_before_t1", product_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      check("lane_timing", {product_valid, lane}, {1'b1, 2'(k)});
    end
    @(posedge clk); @(negedge clk);
    check("valid_fall_t5", {product_valid, busy, state_dbg}, {1'b0, 1'b1, 2'd3});
    #1;
    finish_frame(9);

    // Backpressure on lane 1.
    start_frame(24'h400000, 24'hC00000, 24'h400000, 24'h200000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    product_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_lane1_hold", {product_valid, lane}, {1'b1, 2'd1});
      if (i == 3) product_ready = 1'b1;
    end
    finish_frame(3);

    // Dropped tick at T+3.
    start_frame(24'h123456, 24'hFEDCBA, 24'h7FFFFF, 24'h800000);
    @(posedge clk); #1;
    drop_tick();
    finish_frame(4);
    check("ovr_after_drop", 64'(ovr_seen), 64'(exp_ovr));
`ifdef QPD_SEQ_OVERRUN_CNT_EN
    check("ovr_cnt_one", overrun_cnt, 8'(exp_ovr_since_rst));
`endif

    // Back-to-back frames: tick coincides with filt_done.
    start_frame(24'h0F0F0F, 24'hF0F0F0, 24'h333333, 24'hCCCCCC);
    wait_empty();
    repeat (2) @(posedge clk);
    #1;
    diff = 24'h800000; sum = 24'h7FFFFF; sn = 24'h800000; cs = 24'h000001;
    tick = 1'b1; filt_done = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; filt_done = 1'b0;
    exp_done++;
    push_frame(24'h800000, 24'h7FFFFF, 24'h800000, 24'h000001);
    @(negedge clk);
    check("b2b_done", {done, product_valid, busy}, {1'b1, 1'b0, 1'b1});
    @(posedge clk); @(negedge clk);
    check("b2b_lane0", {product_valid, lane}, {1'b1, 2'd0});
    #1;
    finish_frame(2);
    check("b2b_no_overrun", 64'(ovr_seen), 64'(exp_ovr));

    // Reset mid-frame at T+2.
    start_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid_frame");
    exp_q.delete();
    exp_ovr_since_rst = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_done_after_reset", 64'(done_seen), 64'(exp_done));
    start_frame(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    finish_frame(5);

    // Randomized frames with random backpressure and optional dropped ticks.
    for (int f = 0; f < 20; f++) begin
      stop_rand = 1'b0;
      fork
        begin
          while (!stop_rand) begin
            product_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
        end
        begin
          start_frame(N'($urandom), N'($urandom), N'($urandom), N'($urandom));
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            drop_tick();
          end
          wait_empty();
          stop_rand = 1'b1;
        end
      join
      product_ready = 1'b1;
      finish_frame($urandom_range(1, 8));
    end
    check("rand_overruns", 64'(ovr_seen), 64'(exp_ovr));

    // Counter saturation: stall the frame and drop 300 ticks.
    start_frame(24'h0ABCDE, 24'hF12345, 24'h654321, 24'h9ABCDE);
    product_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drop_tick();
      @(posedge clk); #1;
    end
    product_ready = 1'b1;
    finish_frame(2);
    check("sat_overrun_pulses", 64'(ovr_seen), 64'(exp_ovr));
`ifdef QPD_SEQ_OVERRUN_CNT_EN
    check("ovr_cnt_saturated", overrun_cnt, 8'd255);
`endif

    check("total_done", 64'(done_seen), 64'(exp_done));
    check("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
